// File: rtl/instr_type.sv
// instr_type: shared decode types for the load path (kinds, fault codes, FSM states).
package instr_type;

    typedef enum logic [2:0] {
        lk_lb,
        lk_lh,
        lk_lw,
        lk_lbu,
        lk_lhu,
        lk_invalid
    } load_kind_t;

    typedef enum logic [1:0] {
        lf_none,
        lf_misaligned,
        lf_illegal
    } load_fault_t;

    typedef enum logic [1:0] {
        ls_idle,
        ls_req,
        ls_wait,
        ls_done
    } load_state_t;

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half/word from a memory word, extends it, flags misalignment.
module load_align
    import instr_type::*;
#(
    parameter int XLEN = 32
) (
    input  load_kind_t       kind,
    input  logic [1:0]       lane,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  data,
    output logic             misaligned
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        data = kind == lk_lb  ? {{(XLEN-8){b[7]}}, b} :
               kind == lk_lbu ? {{(XLEN-8){1'b0}}, b} :
               kind == lk_lh  ? {{(XLEN-16){h[15]}}, h} :
               kind == lk_lhu ? {{(XLEN-16){1'b0}}, h} :
               kind == lk_lw  ? rdata : '0;
        misaligned = ((kind == lk_lh || kind == lk_lhu) && lane[0]) ||
                     (kind == lk_lw && lane != 2'b00);
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: one-at-a-time RV32I load engine between execute and writeback.
module load_unit
    import instr_type::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  load_kind_t       req_kind,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [4:0]       req_rd,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_resp_valid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output load_fault_t      wb_fault
);

    load_state_t      state, next;
    load_kind_t       kind, align_kind;
    logic [1:0]       lane, align_lane;
    logic [XLEN-1:0]  ext;
    logic             mis, accept, fault;

    // In IDLE the aligner checks the incoming request; afterwards it extracts for the latched one.
    assign align_kind = state == ls_idle ? req_kind : kind;
    assign align_lane = state == ls_idle ? req_addr[1:0] : lane;
    assign accept     = req_valid && state == ls_idle;
    assign fault      = req_kind == lk_invalid || mis;
    assign req_ready  = state == ls_idle;

    load_align #(.XLEN(XLEN)) u_align (
        .kind       (align_kind),
        .lane       (align_lane),
        .rdata      (mem_rdata),
        .data       (ext),
        .misaligned (mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ls_idle;
        else      state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            ls_idle: next = accept ? (fault ? ls_done : ls_req) : ls_idle;
            ls_req:  next = mem_req_ready ? ls_wait : ls_req;
            ls_wait: next = mem_resp_valid ? ls_done : ls_wait;
            ls_done: next = wb_ready ? ls_idle : ls_done;
            default: next = ls_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind          <= lk_lb;
            lane          <= 2'b00;
            mem_req_valid <= 1'b0;
            wb_valid      <= 1'b0;
            mem_addr      <= '0;
            wb_rd         <= '0;
            wb_data       <= '0;
            wb_fault      <= lf_none;
        end else begin
            mem_req_valid <= next == ls_req;
            wb_valid      <= next == ls_done;
            if (accept) begin
                kind     <= req_kind;
                lane     <= req_addr[1:0];
                mem_addr <= {req_addr[XLEN-1:2], 2'b00};
                wb_rd    <= req_rd;
                wb_data  <= '0;
                wb_fault <= req_kind == lk_invalid ? lf_illegal : mis ? lf_misaligned : lf_none;
            end
            if (state == ls_wait && mem_resp_valid) wb_data <= ext;
        end
    end

endmodule
